// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered sync/blank/position/frame_start outputs.
// Define VGA_TIMING_TESTPATTERN_EN to build in an 8-bar colour test pattern on red/green/blue.
module vga_timing_gen #(
  parameter int unsigned C_h_visible      = 640,
  parameter int unsigned C_h_front        = 16,
  parameter int unsigned C_h_sync         = 96,
  parameter int unsigned C_h_back         = 48,
  parameter int unsigned C_v_visible      = 480,
  parameter int unsigned C_v_front        = 10,
  parameter int unsigned C_v_sync         = 2,
  parameter int unsigned C_v_back         = 33,
  parameter bit          C_hsync_polarity = 1'b0,
  parameter bit          C_vsync_polarity = 1'b0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue
);

  localparam int unsigned H_TOTAL = C_h_visible + C_h_front + C_h_sync + C_h_back;
  localparam int unsigned V_TOTAL = C_v_visible + C_v_front + C_v_sync + C_v_back;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [10:0] H_VIS  = 11'(C_h_visible);
  localparam logic [10:0] H_SS   = 11'(C_h_visible + C_h_front);
  localparam logic [10:0] H_SE   = 11'(C_h_visible + C_h_front + C_h_sync);
  localparam logic [10:0] V_VIS  = 11'(C_v_visible);
  localparam logic [10:0] V_SS   = 11'(C_v_visible + C_v_front);
  localparam logic [10:0] V_SE   = 11'(C_v_visible + C_v_front + C_v_sync);
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic       visible, hsync_act, vsync_act;
  logic       hsync_q, vsync_q, blank_q, frame_start_q;
  logic [9:0] x_q, y_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // vsync depends on v only, so it can only move at a line boundary.
  assign visible   = ({1'b0, h_q} < H_VIS) && ({1'b0, v_q} < V_VIS);
  assign hsync_act = ({1'b0, h_q} >= H_SS) && ({1'b0, h_q} < H_SE);
  assign vsync_act = ({1'b0, v_q} >= V_SS) && ({1'b0, v_q} < V_SE);

  always_ff @(posedge clk_pixel) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~C_hsync_polarity;
      vsync_q       <= ~C_vsync_polarity;
      blank_q       <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_act ? C_hsync_polarity : ~C_hsync_polarity;
      vsync_q       <= vsync_act ? C_vsync_polarity : ~C_vsync_polarity;
      blank_q       <= ~visible;
      x_q           <= h_q;
      y_q           <= v_q;
      frame_start_q <= (h_q == '0) && (v_q == '0);
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_TESTPATTERN_EN
  localparam int unsigned BAR_W    = (C_h_visible / 8 > 0) ? C_h_visible / 8 : 1;
  localparam logic [9:0]  BAR_LAST = 10'(BAR_W - 1);

  // bar_q/wcnt_q describe the same pixel as h_q; the last bar absorbs any remainder.
  logic [2:0] bar_q, bar_d;
  logic [9:0] wcnt_q, wcnt_d;
  logic [8:0] rgb_q;

  always_comb begin
    bar_d  = bar_q;
    wcnt_d = wcnt_q + 10'd1;
    if (h_d == '0) begin
      bar_d  = '0;
      wcnt_d = '0;
    end else if (wcnt_q == BAR_LAST) begin
      wcnt_d = '0;
      if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bar_q  <= '0;
      wcnt_q <= '0;
      rgb_q  <= '0;
    end else begin
      bar_q  <= bar_d;
      wcnt_q <= wcnt_d;
      rgb_q  <= visible ? {{3{~bar_q[2]}}, {3{~bar_q[1]}}, {3{~bar_q[0]}}} : 9'd0;
    end
  end

  assign red   = rgb_q[8:6];
  assign green = rgb_q[5:3];
  assign blue  = rgb_q[2:0];
`else
  assign red   = 3'd0;
  assign green = 3'd0;
  assign blue  = 3'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three parameter sets checked every cycle against a
// raster-position model, plus literal checks on reset, line, frame, vsync and wrap behaviour.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic [8:0] rgb;
  } out_t;

  // Instance 0: defaults, 1: tiny 7x6 raster, 2: medium 56x20 raster with positive syncs.
  localparam int HVIS[3] = '{640, 4, 40};
  localparam int HFP[3]  = '{16, 1, 4};
  localparam int HSW[3]  = '{96, 1, 8};
  localparam int HBP[3]  = '{48, 1, 4};
  localparam int VVIS[3] = '{480, 3, 12};
  localparam int VFP[3]  = '{10, 1, 2};
  localparam int VSW[3]  = '{2, 1, 3};
  localparam int VBP[3]  = '{33, 1, 3};
  localparam bit HPOL[3] = '{1'b0, 1'b0, 1'b1};
  localparam bit VPOL[3] = '{1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hs[3], vs[3], bl[3], fs[3];
  logic [9:0] xs[3], ys[3];
  logic [2:0] r[3], g[3], b[3];

  int n_tests = 0;
  int n_fail  = 0;
  int since_rel = -1;

  always #5 clk = ~clk;

  vga_timing_gen u_dut0 (
    .clk_pixel(clk), .reset(reset), .hsync(hs[0]), .vsync(vs[0]), .blank(bl[0]),
    .x(xs[0]), .y(ys[0]), .frame_start(fs[0]), .red(r[0]), .green(g[0]), .blue(b[0])
  );

  vga_timing_gen #(
    .C_h_visible(4), .C_h_front(1), .C_h_sync(1), .C_h_back(1),
    .C_v_visible(3), .C_v_front(1), .C_v_sync(1), .C_v_back(1)
  ) u_dut1 (
    .clk_pixel(clk), .reset(reset), .hsync(hs[1]), .vsync(vs[1]), .blank(bl[1]),
    .x(xs[1]), .y(ys[1]), .frame_start(fs[1]), .red(r[1]), .green(g[1]), .blue(b[1])
  );

  vga_timing_gen #(
    .C_h_visible(40), .C_h_front(4), .C_h_sync(8), .C_h_back(4),
    .C_v_visible(12), .C_v_front(2), .C_v_sync(3), .C_v_back(3),
    .C_hsync_polarity(1'b1), .C_vsync_polarity(1'b1)
  ) u_dut2 (
    .clk_pixel(clk), .reset(reset), .hsync(hs[2]), .vsync(vs[2]), .blank(bl[2]),
    .x(xs[2]), .y(ys[2]), .frame_start(fs[2]), .red(r[2]), .green(g[2]), .blue(b[2])
  );

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      if (n_fail >= 50) summary();
    end
  endtask

  function automatic out_t get_obs(int d);
    out_t o;
    o.hs  = hs[d];
    o.vs  = vs[d];
    o.bl  = bl[d];
    o.x   = xs[d];
    o.y   = ys[d];
    o.fs  = fs[d];
    o.rgb = {r[d], g[d], b[d]};
    return o;
  endfunction

  // Output after the sr-th clock edge since reset release describes raster position sr-1.
  function automatic out_t model(int d, int sr);
    out_t o;
    int ht, vt, p, h, v, hs0, vs0;
    bit vis;
    o = '0;
    if (sr == 0) begin
      o.hs = ~HPOL[d];
      o.vs = ~VPOL[d];
      o.bl = 1'b1;
      return o;
    end
    ht  = HVIS[d] + HFP[d] + HSW[d] + HBP[d];
    vt  = VVIS[d] + VFP[d] + VSW[d] + VBP[d];
    p   = (sr - 1) % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    vis = (h < HVIS[d]) && (v < VVIS[d]);
    hs0 = HVIS[d] + HFP[d];
    vs0 = VVIS[d] + VFP[d];
    o.hs = (h >= hs0 && h < hs0 + HSW[d]) ? HPOL[d] : ~HPOL[d];
    o.vs = (v >= vs0 && v < vs0 + VSW[d]) ? VPOL[d] : ~VPOL[d];
    o.bl = ~vis;
    o.x  = 10'(h);
    o.y  = 10'(v);
    o.fs = (h == 0) && (v == 0);
`ifdef VGA_TIMING_TESTPATTERN_EN
    if (vis) begin
      int bw, bar;
      logic [2:0] bb;
      bw  = (HVIS[d] / 8 > 0) ? HVIS[d] / 8 : 1;
      bar = h / bw;
      if (bar > 7) bar = 7;
      bb  = 3'(bar);
      o.rgb = {{3{~bb[2]}}, {3{~bb[1]}}, {3{~bb[0]}}};
    end
`endif
    return o;
  endfunction

  always @(posedge clk) begin
    if (reset) since_rel <= 0;
    else if (since_rel >= 0) since_rel <= since_rel + 1;
  end

  always @(negedge clk) begin
    if (since_rel >= 0) begin
      for (int d = 0; d < 3; d++)
        check($sformatf("model_dut%0d", d), 64'(get_obs(d)), 64'(model(d, since_rel)));
    end
  end

  initial begin
    int hcnt, hfirst, last, pulses, vcnt, waited;
    logic prev;

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // First output after release: (0,0), syncs inactive-high on the default instance.
    check("first_out", {xs[0], ys[0], fs[0], bl[0], hs[0], vs[0]},
          {10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1});

    hcnt   = 0;
    hfirst = -1;
    for (int k = 0; k < 800; k++) begin
      if (!hs[0]) begin
        hcnt++;
        if (hfirst < 0) hfirst = k;
      end
      if (k == 639) check("blank_x639", bl[0], 1'b0);
      if (k == 640) check("blank_x640", {bl[0], xs[0]}, {1'b1, 10'd640});
`ifdef VGA_TIMING_TESTPATTERN_EN
      if (k == 0)   check("rgb_x0",   {r[0], g[0], b[0]}, 9'o777);
      if (k == 79)  check("rgb_x79",  {r[0], g[0], b[0]}, 9'o777);
      if (k == 80)  check("rgb_x80",  {r[0], g[0], b[0]}, 9'o770);
      if (k == 560) check("rgb_x560", {r[0], g[0], b[0]}, 9'o000);
      if (k == 700) check("rgb_x700", {r[0], g[0], b[0]}, 9'o000);
`else
      if (k == 0)   check("rgb_off_x0", {r[0], g[0], b[0]}, 9'o000);
`endif
      @(negedge clk);
    end
    check("hsync_low_cycles", hcnt, 96);
    check("hsync_first_x", hfirst, 656);
    check("line_wrap", {xs[0], ys[0]}, {10'd0, 10'd1});

    // Tiny raster: frame_start every 42 cycles.
    last   = -1;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      if (fs[1]) begin
        if (last >= 0) check("fs_period_small", k - last, 42);
        last = k;
        pulses++;
      end
      @(negedge clk);
    end
    check("fs_pulse_count", pulses >= 7, 1'b1);

    // Tiny raster double wrap (6,5) -> (0,0).
    waited = 0;
    while (!(xs[1] == 10'd6 && ys[1] == 10'd5) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("double_wrap_found", waited < 100, 1'b1);
    @(negedge clk);
    check("double_wrap", {xs[1], ys[1], fs[1]}, {10'd0, 10'd0, 1'b1});

    // Medium raster: vsync active (high) 3 lines x 56 = 168 cycles per 1120-cycle frame.
    vcnt = 0;
    prev = vs[2];
    for (int k = 0; k < 2240; k++) begin
      if (vs[2]) vcnt++;
      if (vs[2] && !prev) check("vsync_start", {xs[2], ys[2]}, {10'd0, 10'd14});
      prev = vs[2];
      @(negedge clk);
    end
    check("vsync_cycles_2frames", vcnt, 336);

    // Mid-line reset on the default instance at x=300.
    waited = 0;
    while (xs[0] != 10'd300 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("x300_found", waited < 1000, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_state", {bl[0], hs[0], vs[0], fs[0], xs[0], ys[0], r[0], g[0], b[0]},
          {1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0});
    reset = 1'b0;
    @(negedge clk);
    check("after_midreset", {fs[0], bl[0], xs[0], ys[0]}, {1'b1, 1'b0, 10'd0, 10'd0});

    // Random reset pulses; the per-cycle model checks everything in between.
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(1, 3000)) @(negedge clk);
      reset = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      reset = 1'b0;
    end
    repeat (200) @(negedge clk);
    summary();
  end

endmodule
